// File: rtl/irq_collector.sv
// Interrupt collector: edge-detects a pulse vector into pending bits and presents the
// lowest-index enabled pending source to the CPU as a level request with an ack handshake.
module irq_collector #(
  parameter int NUM_IRQ    = 15,
  parameter int ID_W       = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic               clk_100,
  input  logic               rst_100,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               ack_valid,
  input  logic [ID_W-1:0]    ack_id,
  input  logic               miss_clr,
  output logic               irq_out,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic [CNT_W-1:0]   miss_cnt,
  output logic               ack_err
);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    irq_id_reg, irq_id_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic [NUM_IRQ-1:0] irq_d_reg;
  logic [NUM_IRQ-1:0] pending_reg;
  logic [CNT_W-1:0]   miss_cnt_reg;
  logic               ack_err_reg;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr_mask;
  logic               ack_accept;
  logic               miss_any;
  logic               sel_valid;
  logic [ID_W-1:0]    sel_id;

  assign rise       = irq_in & ~irq_d_reg;
  assign ack_accept = (state_reg == ACTIVE) && ack_valid && (ack_id == irq_id_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_clr
      assign clr_mask[gi] = ack_accept && (irq_id_reg == ID_W'(gi));
    end
  endgenerate

  // A rise on a bit being acked in the same cycle re-pends it and is not a lost edge
  assign miss_any = |(rise & pending_reg & ~clr_mask);

  always_comb begin
    sel_valid = |(pending_reg & irq_en);
    sel_id    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_reg[i] && irq_en[i]) sel_id = ID_W'(i);
    end
  end

  always_comb begin
    state_next   = state_reg;
    irq_id_next  = irq_id_reg;
    gap_cnt_next = gap_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          irq_id_next = sel_id;
          state_next  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ack_accept) begin
          state_next   = GAP;
          gap_cnt_next = '0;
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) state_next = IDLE;
        else gap_cnt_next = gap_cnt_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100) begin
    if (rst_100) begin
      state_reg    <= IDLE;
      irq_id_reg   <= '0;
      gap_cnt_reg  <= '0;
      irq_d_reg    <= '1;  // inputs already high at reset must not fire
      pending_reg  <= '0;
      miss_cnt_reg <= '0;
      ack_err_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      irq_id_reg  <= irq_id_next;
      gap_cnt_reg <= gap_cnt_next;
      irq_d_reg   <= irq_in;
      pending_reg <= (pending_reg & ~clr_mask) | rise;
      ack_err_reg <= ack_valid && !ack_accept;
      if (miss_clr) miss_cnt_reg <= '0;
      else if (miss_any && (miss_cnt_reg != '1)) miss_cnt_reg <= miss_cnt_reg + 1'b1;
    end
  end

  assign irq_out  = (state_reg == ACTIVE);
  assign irq_id   = irq_id_reg;
  assign pending  = pending_reg;
  assign miss_cnt = miss_cnt_reg;
  assign ack_err  = ack_err_reg;

endmodule

// File: tb/tb_irq_collector.sv
// Directed, table-driven check of irq_collector, plus a narrow-counter instance for saturation.
module tb_irq_collector;

  logic        clk_100 = 1'b0;
  logic        rst_100;
  logic [14:0] irq_in;
  logic [14:0] irq_en;
  logic        ack_valid;
  logic [3:0]  ack_id;
  logic        miss_clr;

  logic        irq_out, irq_out2;
  logic [3:0]  irq_id, irq_id2;
  logic [14:0] pending, pending2;
  logic [15:0] miss_cnt;
  logic [1:0]  miss_cnt2;
  logic        ack_err, ack_err2;

  always #5 clk_100 = ~clk_100;

  irq_collector #(.NUM_IRQ(15), .ID_W(4), .GAP_CYCLES(2), .CNT_W(16)) dut (
    .clk_100(clk_100), .rst_100(rst_100), .irq_in(irq_in), .irq_en(irq_en),
    .ack_valid(ack_valid), .ack_id(ack_id), .miss_clr(miss_clr),
    .irq_out(irq_out), .irq_id(irq_id), .pending(pending),
    .miss_cnt(miss_cnt), .ack_err(ack_err)
  );

  irq_collector #(.NUM_IRQ(15), .ID_W(4), .GAP_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk_100(clk_100), .rst_100(rst_100), .irq_in(irq_in), .irq_en(irq_en),
    .ack_valid(ack_valid), .ack_id(ack_id), .miss_clr(miss_clr),
    .irq_out(irq_out2), .irq_id(irq_id2), .pending(pending2),
    .miss_cnt(miss_cnt2), .ack_err(ack_err2)
  );

  typedef struct {
    logic [14:0] in_v;
    logic [14:0] en_v;
    logic        av;
    logic [3:0]  aid;
    logic        clr;
    logic        e_out;
    logic [3:0]  e_id;
    logic [14:0] e_pend;
    logic [15:0] e_miss;
    logic [1:0]  e_miss2;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic [14:0] in_v, input logic [14:0] en_v, input logic av,
                     input logic [3:0] aid, input logic clr, input logic e_out,
                     input logic [3:0] e_id, input logic [14:0] e_pend,
                     input logic [15:0] e_miss, input logic [1:0] e_miss2, input logic e_err);
    vec_t v;
    v.in_v = in_v; v.en_v = en_v; v.av = av; v.aid = aid; v.clr = clr;
    v.e_out = e_out; v.e_id = e_id; v.e_pend = e_pend;
    v.e_miss = e_miss; v.e_miss2 = e_miss2; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".irq_out"}, 32'(irq_out), 32'(v.e_out));
    check({tag, ".irq_id"}, 32'(irq_id), 32'(v.e_id));
    check({tag, ".pending"}, 32'(pending), 32'(v.e_pend));
    check({tag, ".miss_cnt"}, 32'(miss_cnt), 32'(v.e_miss));
    check({tag, ".miss_cnt_w2"}, 32'(miss_cnt2), 32'(v.e_miss2));
    check({tag, ".ack_err"}, 32'(ack_err), 32'(v.e_err));
  endtask

  localparam logic [14:0] EN = 15'h7FFF;

  initial begin
    // in, en, ack_valid, ack_id, miss_clr | irq_out, irq_id, pending, miss, miss_w2, ack_err
    add(15'h0000, EN, 0, 0, 0,  0, 0, 15'h0000, 0, 0, 0);  // idle
    add(15'h0001, EN, 0, 0, 0,  0, 0, 15'h0001, 0, 0, 0);  // bit0 pulse -> pending
    add(15'h0000, EN, 0, 0, 0,  1, 0, 15'h0001, 0, 0, 0);  // raised two edges later
    add(15'h0000, EN, 1, 0, 0,  0, 0, 15'h0000, 0, 0, 0);  // ack 0
    add(15'h0000, EN, 0, 0, 0,  0, 0, 15'h0000, 0, 0, 0);  // gap
    add(15'h0000, EN, 0, 0, 0,  0, 0, 15'h0000, 0, 0, 0);  // idle
    add(15'h000A, EN, 0, 0, 0,  0, 0, 15'h000A, 0, 0, 0);  // bits 3 and 1
    add(15'h0000, EN, 0, 0, 0,  1, 1, 15'h000A, 0, 0, 0);  // lowest first
    add(15'h0000, EN, 0, 0, 0,  1, 1, 15'h000A, 0, 0, 0);
    add(15'h0000, EN, 1, 1, 0,  0, 1, 15'h0008, 0, 0, 0);  // ack 1
    add(15'h0000, EN, 0, 0, 0,  0, 1, 15'h0008, 0, 0, 0);  // gap
    add(15'h0000, EN, 0, 0, 0,  0, 1, 15'h0008, 0, 0, 0);  // gap done -> idle
    add(15'h0000, EN, 0, 0, 0,  1, 3, 15'h0008, 0, 0, 0);  // bit3 raised
    add(15'h0000, EN, 1, 4, 0,  1, 3, 15'h0008, 0, 0, 1);  // wrong ack id
    add(15'h0000, EN, 0, 0, 0,  1, 3, 15'h0008, 0, 0, 0);  // err is one cycle
    add(15'h0000, 15'h7FF7, 0, 0, 0,  1, 3, 15'h0008, 0, 0, 0);  // disable frozen src
    add(15'h0000, 15'h7FF7, 1, 3, 0,  0, 3, 15'h0000, 0, 0, 0);  // ack 3
    add(15'h0000, EN, 1, 0, 0,  0, 3, 15'h0000, 0, 0, 1);  // ack in GAP -> err
    add(15'h0000, EN, 0, 0, 0,  0, 3, 15'h0000, 0, 0, 0);
    add(15'h0000, EN, 0, 0, 0,  0, 3, 15'h0000, 0, 0, 0);
    add(15'h0001, EN, 0, 0, 0,  0, 3, 15'h0001, 0, 0, 0);  // bit0 again
    add(15'h0000, EN, 0, 0, 0,  1, 0, 15'h0001, 0, 0, 0);
    add(15'h0001, EN, 1, 0, 0,  0, 0, 15'h0001, 0, 0, 0);  // ack + rise: set wins, no miss
    add(15'h0000, EN, 0, 0, 0,  0, 0, 15'h0001, 0, 0, 0);
    add(15'h0000, EN, 0, 0, 0,  0, 0, 15'h0001, 0, 0, 0);
    add(15'h0000, EN, 0, 0, 0,  1, 0, 15'h0001, 0, 0, 0);  // re-raised
    add(15'h0000, EN, 1, 0, 0,  0, 0, 15'h0000, 0, 0, 0);
    add(15'h0000, EN, 0, 0, 0,  0, 0, 15'h0000, 0, 0, 0);
    add(15'h0000, EN, 0, 0, 0,  0, 0, 15'h0000, 0, 0, 0);
    add(15'h0020, EN, 0, 0, 0,  0, 0, 15'h0020, 0, 0, 0);  // bit5
    add(15'h0000, EN, 0, 0, 0,  1, 5, 15'h0020, 0, 0, 0);
    add(15'h0020, EN, 0, 0, 0,  1, 5, 15'h0020, 1, 1, 0);  // miss 1
    add(15'h0020, EN, 0, 0, 0,  1, 5, 15'h0020, 1, 1, 0);  // held high: no edge
    add(15'h0000, EN, 0, 0, 0,  1, 5, 15'h0020, 1, 1, 0);
    add(15'h0020, EN, 0, 0, 0,  1, 5, 15'h0020, 2, 2, 0);  // miss 2
    add(15'h0000, EN, 0, 0, 0,  1, 5, 15'h0020, 2, 2, 0);
    add(15'h0020, EN, 0, 0, 0,  1, 5, 15'h0020, 3, 3, 0);
    add(15'h0000, EN, 0, 0, 0,  1, 5, 15'h0020, 3, 3, 0);
    add(15'h0020, EN, 0, 0, 0,  1, 5, 15'h0020, 4, 3, 0);  // narrow counter saturates
    add(15'h0000, EN, 0, 0, 1,  1, 5, 15'h0020, 0, 0, 0);  // miss_clr
    add(15'h0020, EN, 0, 0, 1,  1, 5, 15'h0020, 0, 0, 0);  // clr beats increment
    add(15'h0000, EN, 1, 5, 0,  0, 5, 15'h0000, 0, 0, 0);  // ack 5
    add(15'h0000, EN, 0, 0, 0,  0, 5, 15'h0000, 0, 0, 0);
    add(15'h0000, EN, 0, 0, 0,  0, 5, 15'h0000, 0, 0, 0);

    // Reset with bit14 already high: it must not pend afterwards
    rst_100 = 1'b1; irq_in = 15'h4000; irq_en = EN;
    ack_valid = 1'b0; ack_id = '0; miss_clr = 1'b0;
    repeat (3) step();
    check("reset.irq_out", 32'(irq_out), 32'd0);
    check("reset.irq_id", 32'(irq_id), 32'd0);
    check("reset.pending", 32'(pending), 32'd0);
    check("reset.miss_cnt", 32'(miss_cnt), 32'd0);
    check("reset.ack_err", 32'(ack_err), 32'd0);
    rst_100 = 1'b0;
    repeat (3) step();
    check("held_at_reset.pending", 32'(pending), 32'd0);
    check("held_at_reset.irq_out", 32'(irq_out), 32'd0);
    irq_in = '0;
    step();
    check("held_fall.pending", 32'(pending), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      irq_in = vecs[i].in_v; irq_en = vecs[i].en_v;
      ack_valid = vecs[i].av; ack_id = vecs[i].aid; miss_clr = vecs[i].clr;
      step();
      $display("vec %0d: in=%h en=%h ack=%0d/%0d clr=%0d -> out=%0d id=%0d pend=%h miss=%0d/%0d err=%0d",
               i, vecs[i].in_v, vecs[i].en_v, vecs[i].av, vecs[i].aid, vecs[i].clr,
               irq_out, irq_id, pending, miss_cnt, miss_cnt2, ack_err);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while ACTIVE with a nonzero miss count
    irq_in = 15'h0004; ack_valid = 1'b0; miss_clr = 1'b0; step();
    irq_in = '0; step();
    check("pre_rst.irq_out", 32'(irq_out), 32'd1);
    check("pre_rst.irq_id", 32'(irq_id), 32'd2);
    irq_in = 15'h0004; step();
    check("pre_rst.miss_cnt", 32'(miss_cnt), 32'd1);
    irq_in = '0; rst_100 = 1'b1; step();
    $display("mid-active reset: out=%0d id=%0d pend=%h miss=%0d err=%0d",
             irq_out, irq_id, pending, miss_cnt, ack_err);
    check("rst_active.irq_out", 32'(irq_out), 32'd0);
    check("rst_active.irq_id", 32'(irq_id), 32'd0);
    check("rst_active.pending", 32'(pending), 32'd0);
    check("rst_active.miss_cnt", 32'(miss_cnt), 32'd0);
    check("rst_active.ack_err", 32'(ack_err), 32'd0);
    rst_100 = 1'b0;
    repeat (3) step();
    check("post_rst.irq_out", 32'(irq_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
